// File: rtl/serial_pkg.sv
// Shared types and constants for the serial operand feeder.
package serial_pkg;

   // Default operand width in bits
   localparam int DEFAULT_W = 8;

   // Feeder control states
   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/serial_operand_feeder.sv
// Serial operand feeder: accepts a parallel operand pair and emits both
// operands LSB first, one bit per cycle, for a programmable number of bits.
// A downstream hold inserts bubbles without disturbing the bit stream, and
// the final beat of a pair can accept the next pair so streams run gap-free.
module serial_operand_feeder
   import serial_pkg::*;
#(
   parameter int W = DEFAULT_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_vld,
   output logic                       in_rdy,
   input  logic [W-1:0]               in_a,
   input  logic [W-1:0]               in_b,
   input  logic [$clog2(W+1)-1:0]     in_len,
   input  logic                       hold,
   output logic                       vld,
   output logic                       a,
   output logic                       b,
   output logic                       last
);

   localparam int LW = $clog2(W+1);

   state_t          state_q;
   state_t          state_d;
   logic [W-1:0]    sh_a;
   logic [W-1:0]    sh_b;
   logic [LW-1:0]   cnt;
   logic            xfer;

   // Zero or out-of-range lengths fall back to a full-width operand
   function automatic logic [LW-1:0] eff_len(input logic [LW-1:0] len);
      if ((len == '0) || (len > LW'(W)))
         return LW'(W);
      else
         return len;
   endfunction

   // State register; reset forces IDLE so an in-flight pair is dropped
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Next state and outputs; outputs depend only on state, hold and rst
   always_comb begin
      state_d = state_q;
      in_rdy  = 1'b0;
      vld     = 1'b0;
      a       = 1'b0;
      b       = 1'b0;
      last    = 1'b0;
      xfer    = 1'b0;
      if (rst) begin
         case (state_q)
            IDLE: begin
               in_rdy = 1'b1;
            end
            SHIFT: begin
               vld    = !hold;
               a      = sh_a[0];
               b      = sh_b[0];
               last   = !hold && (cnt == '0);
               in_rdy = !hold && (cnt == '0);
            end
            default: begin
               state_d = IDLE;
            end
         endcase
         xfer = in_vld && in_rdy;
         if (xfer)
            state_d = SHIFT;
         else if (last)
            state_d = IDLE;
      end
   end

   // Shift registers and beat counter: load on transfer, advance on each valid beat
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sh_a <= '0;
         sh_b <= '0;
         cnt  <= '0;
      end else if (xfer) begin
         sh_a <= in_a;
         sh_b <= in_b;
         cnt  <= eff_len(in_len) - LW'(1);
      end else if (vld) begin
         sh_a <= {1'b0, sh_a[W-1:1]};
         sh_b <= {1'b0, sh_b[W-1:1]};
         cnt  <= cnt - LW'(1);
      end
   end

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Directed bench for serial_operand_feeder (W = 8).
module tb_serial_operand_feeder;
   import serial_pkg::*;

   localparam int W = 8;

   logic          clk;
   logic          rst;
   logic          in_vld;
   logic          in_rdy;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic [3:0]    in_len;
   logic          hold;
   logic          vld;
   logic          a;
   logic          b;
   logic          last;

   int total = 0;
   int bad   = 0;

   serial_operand_feeder #(.W(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .in_vld (in_vld),
      .in_rdy (in_rdy),
      .in_a   (in_a),
      .in_b   (in_b),
      .in_len (in_len),
      .hold   (hold),
      .vld    (vld),
      .a      (a),
      .b      (b),
      .last   (last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to 2 time units after the next rising edge
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Check beats [from, to) of a pair of length len, one per cycle
   task automatic beats(input logic [7:0] ea, input logic [7:0] eb,
                        input int from, input int to, input int len);
      for (int i = from; i < to; i++) begin
         #1;
         chk($sformatf("beat%0d_vld", i), {31'd0, vld}, 32'd1);
         chk($sformatf("beat%0d_a", i), {31'd0, a}, {31'd0, ea[i]});
         chk($sformatf("beat%0d_b", i), {31'd0, b}, {31'd0, eb[i]});
         chk($sformatf("beat%0d_last", i), {31'd0, last}, {31'd0, (i == len-1)});
         chk($sformatf("beat%0d_in_rdy", i), {31'd0, in_rdy}, {31'd0, (i == len-1)});
         tick();
      end
   endtask

   // Offer one pair from IDLE; it transfers on the next edge
   task automatic offer(input logic [7:0] va, input logic [7:0] vb, input logic [3:0] vl);
      in_vld = 1'b1;
      in_a   = va;
      in_b   = vb;
      in_len = vl;
      #1;
      chk("offer_in_rdy", {31'd0, in_rdy}, 32'd1);
      chk("offer_vld", {31'd0, vld}, 32'd0);
      tick();
      in_vld = 1'b0;
   endtask

   task automatic idle_chk(input string tag);
      #1;
      chk({tag, "_vld"}, {31'd0, vld}, 32'd0);
      chk({tag, "_last"}, {31'd0, last}, 32'd0);
      chk({tag, "_in_rdy"}, {31'd0, in_rdy}, 32'd1);
      tick();
   endtask

   initial begin
      rst    = 1'b0;
      in_vld = 1'b0;
      in_a   = '0;
      in_b   = '0;
      in_len = '0;
      hold   = 1'b0;

      // reset state
      #3;
      chk("rst_in_rdy", {31'd0, in_rdy}, 32'd0);
      chk("rst_vld", {31'd0, vld}, 32'd0);
      chk("rst_a", {31'd0, a}, 32'd0);
      chk("rst_last", {31'd0, last}, 32'd0);
      tick();
      in_vld = 1'b1;
      #1;
      chk("rst_in_rdy_vld", {31'd0, in_rdy}, 32'd0);
      in_vld = 1'b0;
      tick();
      rst = 1'b1;
      idle_chk("post_rst");

      // basic case
      offer(8'hA5, 8'h3C, 4'd8);
      beats(8'hA5, 8'h3C, 0, 8, 8);
      idle_chk("basic_end");

      // back-to-back pairs, in_vld held high
      in_vld = 1'b1;
      in_a   = 8'h01;
      in_b   = 8'h01;
      in_len = 4'd4;
      #1;
      chk("b2b_in_rdy", {31'd0, in_rdy}, 32'd1);
      tick();
      in_a = 8'hFF;
      in_b = 8'h00;
      beats(8'h01, 8'h01, 0, 4, 4);
      in_vld = 1'b0;
      beats(8'hFF, 8'h00, 0, 4, 4);
      idle_chk("b2b_end");

      // hold bubbles before the third beat
      offer(8'h0F, 8'h00, 4'd8);
      beats(8'h0F, 8'h00, 0, 2, 8);
      hold = 1'b1;
      for (int h = 0; h < 3; h++) begin
         #1;
         chk($sformatf("hold%0d_vld", h), {31'd0, vld}, 32'd0);
         chk($sformatf("hold%0d_last", h), {31'd0, last}, 32'd0);
         chk($sformatf("hold%0d_in_rdy", h), {31'd0, in_rdy}, 32'd0);
         chk($sformatf("hold%0d_a", h), {31'd0, a}, 32'd1);
         tick();
      end
      hold = 1'b0;
      beats(8'h0F, 8'h00, 2, 8, 8);
      idle_chk("hold_end");

      // length boundaries
      offer(8'h01, 8'h01, 4'd1);
      beats(8'h01, 8'h01, 0, 1, 1);
      idle_chk("len1_end");
      offer(8'hA5, 8'h3C, 4'd0);
      beats(8'hA5, 8'h3C, 0, 8, 8);
      idle_chk("len0_end");
      offer(8'h5A, 8'hC3, 4'd9);
      beats(8'h5A, 8'hC3, 0, 8, 8);
      idle_chk("len9_end");
      offer(8'h36, 8'h81, 4'd3);
      beats(8'h36, 8'h81, 0, 3, 3);
      idle_chk("len3_end");

      // reset mid-operation
      offer(8'hFF, 8'hFF, 4'd8);
      beats(8'hFF, 8'hFF, 0, 3, 8);
      #1;
      chk("midrst_pre_vld", {31'd0, vld}, 32'd1);
      rst = 1'b0;
      #1;
      chk("midrst_vld", {31'd0, vld}, 32'd0);
      chk("midrst_last", {31'd0, last}, 32'd0);
      chk("midrst_in_rdy", {31'd0, in_rdy}, 32'd0);
      chk("midrst_a", {31'd0, a}, 32'd0);
      tick();
      #1;
      chk("midrst_hold_vld", {31'd0, vld}, 32'd0);
      rst = 1'b1;
      #1;
      chk("midrst_rel_vld", {31'd0, vld}, 32'd0);
      chk("midrst_rel_in_rdy", {31'd0, in_rdy}, 32'd1);
      tick();
      offer(8'h80, 8'h00, 4'd8);
      beats(8'h80, 8'h00, 0, 8, 8);
      idle_chk("midrst_end");

      // backpressure: offered pair waits for the last beat
      in_vld = 1'b1;
      in_a   = 8'hA5;
      in_b   = 8'h3C;
      in_len = 4'd8;
      #1;
      chk("bp_in_rdy", {31'd0, in_rdy}, 32'd1);
      tick();
      in_a = 8'hFF;
      in_b = 8'hFF;
      beats(8'hA5, 8'h3C, 0, 4, 8);
      in_a = 8'h11;
      in_b = 8'h22;
      beats(8'hA5, 8'h3C, 4, 8, 8);
      in_vld = 1'b0;
      beats(8'h11, 8'h22, 0, 8, 8);
      idle_chk("bp_end");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serial_operand_feeder.md
SERIAL_OPERAND_FEEDER -- requirements
Module: serial_operand_feeder

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the operand width in bits (W >= 2).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset: asynchronous, active-low.
REQ-004 The block SHALL have port in_vld, input, 1, meaning an operand pair is offered.
REQ-005 The block SHALL have port in_rdy, output, 1, meaning the block accepts the offered pair this cycle; the transfer occurs when in_vld & in_rdy.
REQ-006 The block SHALL have ports in_a and in_b, input, W each, the parallel operands.
REQ-007 The block SHALL have port in_len, input, $clog2(W+1), the number of bits to emit.
REQ-008 The block SHALL have port hold, input, 1, a downstream bubble request.
REQ-009 The block SHALL have port vld, output, 1, meaning the serial bit is valid.
REQ-010 The block SHALL have ports a and b, output, 1 each, the serial operand bits, LSB first.
REQ-011 The block SHALL have port last, output, 1, marking the final valid bit of an operand pair.

Function
REQ-012 The block SHALL implement a two-state FSM: IDLE and SHIFT.
REQ-013 In IDLE, in_rdy SHALL be 1 and vld SHALL be 0.
REQ-014 On a transfer, the block SHALL load shift registers from in_a/in_b, load counter cnt = eff_len-1, and enter SHIFT.
REQ-015 eff_len SHALL equal in_len when 1 <= in_len <= W, and SHALL equal W otherwise (in_len == 0 or in_len > W).
REQ-016 First-bit latency: a transfer at edge k SHALL produce the first vld=1 bit in the cycle after edge k, unless hold is 1.
REQ-017 In SHIFT, vld SHALL equal !hold; a and b SHALL equal bit 0 of the respective shift registers; last SHALL equal vld & (cnt == 0).
REQ-018 On each edge with vld=1, both shift registers SHALL shift right by one, filling with 0, and cnt SHALL decrement.
REQ-019 While hold=1 in SHIFT, shift registers, cnt and state SHALL be unchanged, and vld and last SHALL be 0.
REQ-020 On an edge with last=1, the FSM SHALL go to IDLE, unless a transfer occurs on the same edge.
REQ-021 In SHIFT, in_rdy SHALL equal last, allowing back-to-back pairs with no bubble.
REQ-022 A transfer coincident with last SHALL reload the registers per REQ-014 and SHALL remain in SHIFT.
REQ-023 In SHIFT, in_rdy SHALL be 0 when last=0; in_a, in_b and in_len SHALL be ignored when no transfer occurs.
REQ-024 Exactly eff_len vld beats SHALL be emitted per accepted pair, and exactly one of them SHALL carry last=1.
REQ-025 a, b, vld, last and in_rdy SHALL be combinational functions of registered state, hold and rst only; there SHALL be no path from in_vld, in_a, in_b or in_len to any output.

Reset
REQ-026 While rst=0, the FSM SHALL be IDLE, shift registers and cnt SHALL be 0, and vld, a, b and last SHALL be 0.
REQ-027 While rst=0, in_rdy SHALL be 0, gated combinationally by rst.
REQ-028 Assertion of rst mid-operation SHALL abort the pair immediately: no further vld beats and no last for that pair.
REQ-029 After rst deasserts, the block SHALL accept a new pair on the first clock edge with in_vld=1.

Structure
REQ-030 The state enum (IDLE, SHIFT) and the default width constant SHALL live in shared package serial_pkg.
REQ-031 The block SHALL be a single flat module with no sub-module; the shift registers and counter are inline.

Verification
REQ-032 Basic case: W=8, in_a=8'hA5, in_b=8'h3C, in_len=8, hold=0 -> 8 beats with a=1,0,1,0,0,1,0,1 and b=0,0,1,1,1,1,0,0; last only on beat 8; in_rdy=1 on beat 8.
REQ-033 Back-to-back: in_vld held 1 with pairs (8'h01,8'h01) then (8'hFF,8'h00), in_len=4 -> 8 contiguous vld beats; last on beats 4 and 8; second pair a=1,1,1,1.
REQ-034 Hold: hold=1 during beats 3-5 of in_a=8'h0F, in_len=8 -> vld=0 for 3 cycles; the bit sequence 1,1,1,1,0,0,0,0 is unaltered; last fires on the 8th valid beat.
REQ-035 Length boundaries: in_len=1 -> single beat with last=1; in_len=0 and in_len=9 -> 8 beats each.
REQ-036 Reset mid-operation: rst=0 after beat 3 -> vld, last and in_rdy go 0 asynchronously; after release, a new pair 8'h80,in_len=8 -> last coincides with a=1.
REQ-037 Backpressure: in_vld=1 during beats 1-7 of a pair -> no transfer until the last beat; in_a/in_b changes during that window have no effect.
